nibble_mul_seq: RTL and testbench
=================================

# nibble_mul_seq

Sequencer and accumulator wrapped around the registered 4x4 array multiplier (`multi`). It accepts an 8x8 unsigned multiply request and splits it into four nibble-pair products. It issues those pairs on the multiplier's `a`/`b` inputs, then consumes the registered 8-bit `product` and shift-accumulates the four results into a 16-bit product. It sits directly upstream of the multiplier as its operand feeder, and directly downstream of it as its product consumer.

## Interface
- `MUL_LAT`, default 1: pipeline latency of the attached multiplier in cycles. Legal range 1–4. The value 1 matches `multi`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request strobe. Sampled only when `busy`=0.
- `op_a`  in  8: multiplicand. Captured on accepted `start`.
- `op_b`  in  8: multiplier. Captured on accepted `start`.
- `busy`  out  1: high while a job is in flight.
- `done`  out  1: one-cycle pulse. `result` is valid and new in this cycle.
- `result`  out  16: op_a*op_b. Holds until the next `done`.
- `mul_a`  out  4: nibble to multiplier `a`.
- `mul_b`  out  4: nibble to multiplier `b`.
- `mul_p`  in  8: multiplier `product`. Valid MUL_LAT cycles after the matching issue.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - `busy`=0.
  - If `start`=1: latch op_a/op_b, clear the 16-bit accumulator, and go to ISSUE with idx=0.
- **ISSUE** (4 cycles, idx 0..3)
  - Drive the nibble pair for idx:
    - idx 0: (a[3:0], b[3:0]), shift 0
    - idx 1: (a[7:4], b[3:0]), shift 4
    - idx 2: (a[3:0], b[7:4]), shift 4
    - idx 3: (a[7:4], b[7:4]), shift 8
  - Push {valid, shift} into a MUL_LAT-deep tag pipe.
  - After idx 3, go to DRAIN.
- **DRAIN**: wait until the tag pipe is empty. Stay MUL_LAT cycles; the final accumulate happens on the last DRAIN edge. Then go to DONE.
- **Accumulate rule**: in any cycle where the tag pipe output is valid, acc <= acc + ({8'b0, mul_p} << shift).
  - All arithmetic is unsigned, 16 bits wide.
  - Overflow cannot occur (max 0xFE01).
- **DONE**
  - Copy acc to `result` and pulse `done` for one cycle.
  - `busy`=0 in this cycle, so a `start` here is accepted (back-to-back).
  - Next state is ISSUE if `start` is accepted, otherwise IDLE.
- `start` while `busy`=1 is ignored. It is neither queued nor flagged.
- `mul_a`/`mul_b` are 0 outside ISSUE. `mul_p` is ignored when the tag is not valid.
- **Reset** (any state, including mid-job):
  - Next cycle: state IDLE, `busy`=0, `done`=0, `result`=0, `mul_a`=`mul_b`=0.
  - Tag pipe and accumulator are cleared, so in-flight products are discarded.
  - A `start` in the same cycle as `rst` is ignored.

## Timing
- Cycle 0: `start`=1 with `busy`=0 (acceptance edge at end of cycle 0).
- Cycles 1–4: ISSUE, `busy`=1, mul_a/mul_b carry pair idx=c-1.
- Product of the cycle-c issue appears on `mul_p` in cycle c+MUL_LAT and is accumulated at the end of that cycle.
- Cycles 5 .. 4+MUL_LAT: DRAIN, `busy`=1.
- Cycle 5+MUL_LAT: DONE, `done`=1, `result` valid, `busy`=0.
  - MUL_LAT=1 → done in cycle 6.
  - MUL_LAT=3 → done in cycle 8.
- Throughput: one job per 5+MUL_LAT cycles with back-to-back starts (start in the DONE cycle).
- Reset values: `busy`=0, `done`=0, `result`=16'h0000, `mul_a`=4'h0, `mul_b`=4'h0.

## Test plan
- **Reset**: assert `rst` for 2 cycles with `start`=1 → all outputs 0 and no `done` for 10 cycles after release with `start`=0.
- **Operand ordering**: op_a=0x12, op_b=0x34, MUL_LAT=1, real `multi` attached.
  - mul_a/mul_b in cycles 1–4 = (2,4), (1,4), (2,3), (1,3).
  - `done` in cycle 6 with result=0x03A8.
- **Extremes**: op_a=0xFF, op_b=0xFF → result=0xFE01. op_a=0x00, op_b=0xA5 → result=0x0000. Each gives exactly one `done` pulse.
- **Ignored start / back-to-back**:
  - `start` with 0x03*0x05 in cycle 2 is ignored; first job 0x10*0x10 → 0x0100 in cycle 6.
  - `start` with 0x07*0x09 in cycle 6 → 0x003F in cycle 12.
- **Reset mid-job**: start 0xFF*0xFF, assert `rst` in cycle 3, then start 0x02*0x03 → only result 0x0006 is reported; no 0xFE01 ever appears.
- **Latency parameter**: MUL_LAT=3 with a 3-stage behavioural multiplier model, op_a=0xAB, op_b=0xCD → `done` in cycle 8 with result=0x88EF.

Source files
------------

// File: rtl/nibble_mul_seq_if.sv
// Request/response and multiplier-side signals of the nibble multiply sequencer.
// slave is the sequencer's view; master is the requester plus attached multiplier.
interface nibble_mul_seq_if;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;

  modport slave (
    input  start, op_a, op_b, mul_p,
    output busy, done, result, mul_a, mul_b
  );

  modport master (
    output start, op_a, op_b, mul_p,
    input  busy, done, result, mul_a, mul_b
  );
endinterface

// File: rtl/nibble_mul_seq.sv
// 8x8 unsigned multiply built from four nibble products on an external 4x4 multiplier.
// Latency 5+MUL_LAT cycles from accepted start to done; start is dropped while busy.
module nibble_mul_seq #(
  parameter int MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  nibble_mul_seq_if.slave io
);

  localparam logic [2:0] LAST_DRAIN = 3'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  drain_q, drain_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] result_q, result_d;

  // Tag pipe tracks which multiplier output cycles carry a product and its weight.
  // Shift code: 0 -> <<0, 1 -> <<4, 2 -> <<8.
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [1:0]         tag_sh_q [MUL_LAT];

  logic        push;
  logic [1:0]  push_sh;
  logic        accept;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [15:0] prod_ext;
  logic [15:0] prod_shifted;

  assign prod_ext = {8'b0, io.mul_p};

  always_comb begin
    prod_shifted = prod_ext;
    case (tag_sh_q[MUL_LAT-1])
      2'd1:    prod_shifted = prod_ext << 4;
      2'd2:    prod_shifted = prod_ext << 8;
      default: prod_shifted = prod_ext;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    accept   = 1'b0;
    push     = 1'b0;
    push_sh  = 2'd0;
    nib_a    = 4'h0;
    nib_b    = 4'h0;

    acc_d = acc_q;
    if (tag_vld_q[MUL_LAT-1]) begin
      acc_d = acc_q + prod_shifted;
    end

    case (state_q)
      IDLE: begin
        accept = io.start;
      end
      ISSUE: begin
        push  = 1'b1;
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; push_sh = 2'd0; end
          2'd1: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; push_sh = 2'd1; end
          2'd2: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; push_sh = 2'd1; end
          default: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; push_sh = 2'd2; end
        endcase
        if (idx_q == 2'd3) begin
          state_d = DRAIN;
          drain_d = 3'd0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 3'd1;
        // The last in-flight product lands on this edge, so publish the updated sum.
        if (drain_q == LAST_DRAIN) begin
          state_d  = DONE;
          result_d = acc_d;
        end
      end
      DONE: begin
        state_d = IDLE;
        accept  = io.start;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      a_d     = io.op_a;
      b_d     = io.op_b;
      acc_d   = 16'h0000;
      idx_d   = 2'd0;
      state_d = ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      drain_q  <= 3'd0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      acc_q    <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_sh_q[i] <= 2'd0;
      end
    end else begin
      tag_vld_q[0] <= push;
      tag_sh_q[0]  <= push_sh;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_sh_q[i]  <= tag_sh_q[i-1];
      end
    end
  end

  assign io.busy   = (state_q == ISSUE) || (state_q == DRAIN);
  assign io.done   = (state_q == DONE);
  assign io.result = result_q;
  assign io.mul_a  = nib_a;
  assign io.mul_b  = nib_b;

endmodule

// File: tb/tb_nibble_mul_seq.sv
// Bench for nibble_mul_seq: one instance with a 1-stage multiplier, one with a 3-stage one.
module tb_nibble_mul_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_mul_seq_if if1 ();
  nibble_mul_seq_if if3 ();

  nibble_mul_seq #(.MUL_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .io(if1.slave));
  nibble_mul_seq #(.MUL_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .io(if3.slave));

  // Behavioural multipliers: registered product, 1 and 3 stages deep.
  logic [7:0] p1_s0;
  logic [7:0] p3_s0, p3_s1, p3_s2;
  always @(posedge clk) begin
    p1_s0 <= {4'b0, if1.mul_a} * {4'b0, if1.mul_b};
    p3_s0 <= {4'b0, if3.mul_a} * {4'b0, if3.mul_b};
    p3_s1 <= p3_s0;
    p3_s2 <= p3_s1;
  end
  assign if1.mul_p = p1_s0;
  assign if3.mul_p = p3_s2;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_res [$];
  int          exp_cyc [$];

  task automatic set_req1(input logic s, input logic [7:0] a, input logic [7:0] b);
    if1.start = s; if1.op_a = a; if1.op_b = b;
  endtask

  task automatic test_reset;
    int dones;
    rst = 1'b1;
    set_req1(1'b1, 8'hFF, 8'hFF);
    if3.start = 1'b1; if3.op_a = 8'hFF; if3.op_b = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_req1(1'b0, 8'h00, 8'h00);
    if3.start = 1'b0;
    checks++;
    if ({if1.busy, if1.done, if1.result, if1.mul_a, if1.mul_b} !== 26'h0) begin
      failures++;
      $display("FAIL reset_outputs_lat1 busy=%b done=%b result=%h mul_a=%h mul_b=%h required all zero",
               if1.busy, if1.done, if1.result, if1.mul_a, if1.mul_b);
    end
    checks++;
    if ({if3.busy, if3.done, if3.result, if3.mul_a, if3.mul_b} !== 26'h0) begin
      failures++;
      $display("FAIL reset_outputs_lat3 busy=%b done=%b result=%h mul_a=%h mul_b=%h required all zero",
               if3.busy, if3.done, if3.result, if3.mul_a, if3.mul_b);
    end
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1 || if3.done === 1'b1 || if1.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL reset_idle_quiet activity_cycles=%0d required 0", dones);
    end
  endtask

  task automatic test_ordering;
    logic [3:0] exp_a [4] = '{4'h2, 4'h1, 4'h2, 4'h1};
    logic [3:0] exp_b [4] = '{4'h4, 4'h4, 4'h3, 4'h3};
    logic [15:0] er;
    int ec, dones;
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1) begin
        dones++;
        checks++;
        if (exp_res.size() == 0) begin
          failures++;
          $display("FAIL order_unexpected_done cycle=%0d result=%h required no done", c, if1.result);
        end else begin
          er = exp_res.pop_front(); ec = exp_cyc.pop_front();
          if (if1.result !== er) begin
            failures++;
            $display("FAIL order_result got=%h required=%h", if1.result, er);
          end
          checks++;
          if (c != ec) begin
            failures++;
            $display("FAIL order_done_cycle got=%0d required=%0d", c, ec);
          end
        end
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (if1.mul_a !== exp_a[c-1] || if1.mul_b !== exp_b[c-1] || if1.busy !== 1'b1) begin
          failures++;
          $display("FAIL order_pair idx=%0d got a=%h b=%h busy=%b required a=%h b=%h busy=1",
                   c - 1, if1.mul_a, if1.mul_b, if1.busy, exp_a[c-1], exp_b[c-1]);
        end
      end
      if (c == 5) begin
        checks++;
        if (if1.mul_a !== 4'h0 || if1.mul_b !== 4'h0 || if1.busy !== 1'b1) begin
          failures++;
          $display("FAIL order_drain got a=%h b=%h busy=%b required a=0 b=0 busy=1",
                   if1.mul_a, if1.mul_b, if1.busy);
        end
      end
      if (c == 0) begin
        set_req1(1'b1, 8'h12, 8'h34);
        exp_res.push_back(16'(8'h12) * 16'(8'h34));
        exp_cyc.push_back(6);
      end else begin
        set_req1(1'b0, 8'h00, 8'h00);
      end
    end
    checks++;
    if (dones != 1 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL order_done_count got=%0d pending=%0d required 1 and 0", dones, exp_res.size());
    end
  endtask

  task automatic test_extremes;
    logic [7:0] ta [2] = '{8'hFF, 8'h00};
    logic [7:0] tb [2] = '{8'hFF, 8'hA5};
    logic [15:0] er;
    int ec, dones;
    for (int t = 0; t < 2; t++) begin
      dones = 0;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (if1.done === 1'b1) begin
          dones++;
          checks++;
          if (exp_res.size() == 0) begin
            failures++;
            $display("FAIL extreme_unexpected_done cycle=%0d result=%h required no done", c, if1.result);
          end else begin
            er = exp_res.pop_front(); ec = exp_cyc.pop_front();
            if (if1.result !== er || c != ec) begin
              failures++;
              $display("FAIL extreme_result got=%h at cycle %0d required=%h at cycle %0d",
                       if1.result, c, er, ec);
            end
          end
        end
        if (c == 0) begin
          set_req1(1'b1, ta[t], tb[t]);
          exp_res.push_back(16'(ta[t]) * 16'(tb[t]));
          exp_cyc.push_back(6);
        end else begin
          set_req1(1'b0, 8'h00, 8'h00);
        end
      end
      checks++;
      if (dones != 1) begin
        failures++;
        $display("FAIL extreme_done_count case=%0d got=%0d required=1", t, dones);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] er;
    int ec, dones;
    dones = 0;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1) begin
        dones++;
        checks++;
        if (exp_res.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_done cycle=%0d result=%h required no done", c, if1.result);
        end else begin
          er = exp_res.pop_front(); ec = exp_cyc.pop_front();
          if (if1.result !== er || c != ec) begin
            failures++;
            $display("FAIL b2b_result got=%h at cycle %0d required=%h at cycle %0d",
                     if1.result, c, er, ec);
          end
        end
      end
      case (c)
        0: begin
          set_req1(1'b1, 8'h10, 8'h10);
          exp_res.push_back(16'h0100);
          exp_cyc.push_back(6);
        end
        2: begin
          checks++;
          if (if1.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_busy_during_ignored_start got=%b required=1", if1.busy);
          end
          set_req1(1'b1, 8'h03, 8'h05);
        end
        6: begin
          checks++;
          if (if1.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_in_done got=%b required=0", if1.busy);
          end
          set_req1(1'b1, 8'h07, 8'h09);
          exp_res.push_back(16'h003F);
          exp_cyc.push_back(12);
        end
        default: set_req1(1'b0, 8'h00, 8'h00);
      endcase
    end
    checks++;
    if (dones != 2 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d pending=%0d required 2 and 0", dones, exp_res.size());
    end
  endtask

  task automatic test_reset_mid_job;
    logic [15:0] er;
    int ec, dones;
    dones = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (if1.done === 1'b1) begin
        dones++;
        checks++;
        if (exp_res.size() == 0) begin
          failures++;
          $display("FAIL midrst_unexpected_done cycle=%0d result=%h required no done", c, if1.result);
        end else begin
          er = exp_res.pop_front(); ec = exp_cyc.pop_front();
          if (if1.result !== er || c != ec) begin
            failures++;
            $display("FAIL midrst_result got=%h at cycle %0d required=%h at cycle %0d",
                     if1.result, c, er, ec);
          end
        end
      end
      if (c == 4) begin
        checks++;
        if (if1.busy !== 1'b0 || if1.result !== 16'h0000) begin
          failures++;
          $display("FAIL midrst_after_reset busy=%b result=%h required busy=0 result=0000",
                   if1.busy, if1.result);
        end
      end
      rst = (c == 3);
      case (c)
        0: set_req1(1'b1, 8'hFF, 8'hFF);
        4: begin
          set_req1(1'b1, 8'h02, 8'h03);
          exp_res.push_back(16'h0006);
          exp_cyc.push_back(10);
        end
        default: set_req1(1'b0, 8'h00, 8'h00);
      endcase
    end
    checks++;
    if (dones != 1 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL midrst_done_count got=%0d pending=%0d required 1 and 0", dones, exp_res.size());
    end
  endtask

  task automatic test_latency;
    logic [15:0] er;
    int ec, dones;
    dones = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (if3.done === 1'b1) begin
        dones++;
        checks++;
        if (exp_res.size() == 0) begin
          failures++;
          $display("FAIL lat3_unexpected_done cycle=%0d result=%h required no done", c, if3.result);
        end else begin
          er = exp_res.pop_front(); ec = exp_cyc.pop_front();
          if (if3.result !== er || c != ec) begin
            failures++;
            $display("FAIL lat3_result got=%h at cycle %0d required=%h at cycle %0d",
                     if3.result, c, er, ec);
          end
        end
      end
      if (c == 7) begin
        checks++;
        if (if3.busy !== 1'b1 || if3.done !== 1'b0) begin
          failures++;
          $display("FAIL lat3_drain busy=%b done=%b required busy=1 done=0", if3.busy, if3.done);
        end
      end
      if (c == 0) begin
        if3.start = 1'b1; if3.op_a = 8'hAB; if3.op_b = 8'hCD;
        exp_res.push_back(16'(8'hAB) * 16'(8'hCD));
        exp_cyc.push_back(8);
      end else begin
        if3.start = 1'b0; if3.op_a = 8'h00; if3.op_b = 8'h00;
      end
    end
    checks++;
    if (dones != 1 || exp_res.size() != 0) begin
      failures++;
      $display("FAIL lat3_done_count got=%0d pending=%0d required 1 and 0", dones, exp_res.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    set_req1(1'b0, 8'h00, 8'h00);
    if3.start = 1'b0; if3.op_a = 8'h00; if3.op_b = 8'h00;
    test_reset();
    test_ordering();
    test_extremes();
    test_back_to_back();
    test_reset_mid_job();
    test_latency();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
